// File: rtl/dm_responder.sv
// dm_responder: memory-side responder for the CPU data-memory port.
//
// Holds a DEPTH x DATA_W word store. Before the CPU runs, a handshaked
// preload port fills the store. While the preload is in progress the
// block holds the CPU core in reset. After the preload the block serves
// the CPU with one-cycle reads and bit-masked, write-first writes.
//
// Ports
//   clk, rst          single clock; synchronous active-high reset
//   dm_addr           CPU word address
//   dm_data_in        CPU write data
//   dm_web            CPU write enable, active low (0 = write, 1 = read)
//   dm_bweb           CPU bit write mask, active low per bit
//   dm_data_out       registered read data (0 outside RUN)
//   ld_start/ld_base  start a preload at word address ld_base
//   ld_valid/ld_data  preload word stream, ld_last marks the final word
//   ld_ready          a preload word is accepted this cycle (LOAD)
//   ld_done           preload finished (RUN)
//   cpu_rst           reset to the CPU core, released only in RUN
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for ld_start; CPU held in reset, CPU port ignored
// LOAD  | accepting preload words into mem[ptr], ptr auto-increments
// RUN   | preload done; CPU released and its port is serviced

module dm_responder #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_data_in,
    input  logic              dm_web,
    input  logic [DATA_W-1:0] dm_bweb,
    output logic [DATA_W-1:0] dm_data_out,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              cpu_rst
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]   dout_q, dout_d;

    // Store contents are deliberately not reset.
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   merged;

    // Combinational read of the addressed word feeds both the registered
    // read path and the read-modify-write merge for masked stores.
    assign rd_word = mem[dm_addr];
    assign merged  = (rd_word & dm_bweb) | (dm_data_in & ~dm_bweb);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        dout_d    = '0;
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = ld_data;
        ld_ready  = 1'b0;
        ld_done   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ld_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = ld_base;
                end
            end

            ST_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = ptr_q;
                    mem_wdata = ld_data;
                    // DEPTH is 2**ADDR_W, so the natural overflow wraps.
                    ptr_d     = ptr_q + 1'b1;
                    if (ld_last) begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                ld_done = 1'b1;
                if (!dm_web) begin
                    mem_we    = 1'b1;
                    mem_waddr = dm_addr;
                    mem_wdata = merged;
                    dout_d    = merged;   // write-first
                end else begin
                    dout_d    = rd_word;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset is ORed in so the core sees reset in the very cycle rst rises,
    // even if the state register still holds RUN.
    assign cpu_rst     = rst | (state_q != ST_RUN);
    assign dm_data_out = dout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            dout_q  <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: directed scenarios plus randomized
// traffic checked against a word-level reference model of the store.

module tb_dm_responder;

    localparam int AW    = 14;
    localparam int DW    = 32;
    localparam int DEPTH = 16384;

    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_RUN  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_data_in;
    logic          dm_web;
    logic [DW-1:0] dm_bweb;
    logic [DW-1:0] dm_data_out;
    logic          ld_start;
    logic [AW-1:0] ld_base;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          ld_done;
    logic          cpu_rst;

    always #5 clk = ~clk;

    dm_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .dm_addr     (dm_addr),
        .dm_data_in  (dm_data_in),
        .dm_web      (dm_web),
        .dm_bweb     (dm_bweb),
        .dm_data_out (dm_data_out),
        .ld_start    (ld_start),
        .ld_base     (ld_base),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .ld_done     (ld_done),
        .cpu_rst     (cpu_rst)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase, preload pointer, known words of the store.
    int            mdl_phase = P_IDLE;
    int            mdl_ptr   = 0;
    logic [DW-1:0] mdl_mem [int];
    logic [DW-1:0] exp_out   = '0;
    bit            out_known = 1'b1;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: update the model from the inputs seen at the edge, then
    // compare the DUT outputs 1 time unit later.
    task automatic tick();
        int            a;
        logic [DW-1:0] old_w;
        logic [DW-1:0] nw;
        @(posedge clk);
        if (rst) begin
            mdl_phase = P_IDLE;
            mdl_ptr   = 0;
            exp_out   = '0;
            out_known = 1'b1;
        end else if (mdl_phase == P_IDLE) begin
            exp_out   = '0;
            out_known = 1'b1;
            if (ld_start) begin
                mdl_phase = P_LOAD;
                mdl_ptr   = int'(ld_base);
            end
        end else if (mdl_phase == P_LOAD) begin
            exp_out   = '0;
            out_known = 1'b1;
            if (ld_valid) begin
                mdl_mem[mdl_ptr] = ld_data;
                mdl_ptr = (mdl_ptr + 1) % DEPTH;
                if (ld_last) mdl_phase = P_RUN;
            end
        end else begin
            a = int'(dm_addr);
            if (mdl_mem.exists(a)) begin
                old_w = mdl_mem[a];
                nw    = dm_web ? old_w : ((old_w & dm_bweb) | (dm_data_in & ~dm_bweb));
                if (!dm_web) mdl_mem[a] = nw;
                exp_out   = nw;
                out_known = 1'b1;
            end else if (!dm_web && dm_bweb == '0) begin
                mdl_mem[a] = dm_data_in;
                exp_out    = dm_data_in;
                out_known  = 1'b1;
            end else begin
                out_known = 1'b0;
                if (!dm_web) mdl_mem.delete(a);
            end
        end
        #1;
        check("ld_ready", {31'b0, ld_ready}, {31'b0, mdl_phase == P_LOAD});
        check("ld_done",  {31'b0, ld_done},  {31'b0, mdl_phase == P_RUN});
        check("cpu_rst",  {31'b0, cpu_rst},  {31'b0, mdl_phase != P_RUN});
        if (out_known) check("dm_data_out", dm_data_out, exp_out);
    endtask

    task automatic preload(input logic [AW-1:0] base, input logic [DW-1:0] w[$],
                           input int gap_idx, input bit rnd);
        ld_start = 1'b1;
        ld_base  = base;
        ld_valid = 1'b0;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < w.size(); i++) begin
            if (i == gap_idx || (rnd && $urandom_range(3) == 0)) begin
                ld_valid = 1'b0;
                ld_data  = $urandom;
                ld_last  = 1'($urandom_range(1));
                ld_start = rnd ? 1'($urandom_range(1)) : 1'b0;
                ld_base  = AW'($urandom);
                tick();
            end
            ld_valid = 1'b1;
            ld_data  = w[i];
            ld_last  = (i == w.size() - 1);
            ld_start = rnd ? 1'($urandom_range(1)) : 1'b0;
            ld_base  = AW'($urandom);
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_start = 1'b0;
        check("run_done_after_last", {31'b0, ld_done}, 32'd1);
        check("run_cpu_rst_low",     {31'b0, cpu_rst}, 32'd0);
    endtask

    task automatic cpu(input bit web, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] bw);
        dm_web     = web;
        dm_addr    = a;
        dm_data_in = d;
        dm_bweb    = bw;
        tick();
        dm_web     = 1'b1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    logic [DW-1:0] wq [$];
    logic [DW-1:0] first_blk [$];
    int            keys [$];
    int            k;

    initial begin
        rst = 1'b1; dm_addr = '0; dm_data_in = '0; dm_web = 1'b1; dm_bweb = '1;
        ld_start = 1'b0; ld_base = '0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;

        do_reset(2);
        check("rst_dout",     dm_data_out, 32'd0);
        check("rst_cpu_rst",  {31'b0, cpu_rst},  32'd1);
        check("rst_ld_ready", {31'b0, ld_ready}, 32'd0);
        check("rst_ld_done",  {31'b0, ld_done},  32'd0);

        // Known background block at 0x0000..0x001F.
        first_blk = {};
        for (int i = 0; i < 32; i++) first_blk.push_back($urandom);
        preload(14'h0000, first_blk, -1, 1'b1);

        // CPU write while in IDLE must not reach the store.
        do_reset(1);
        cpu(1'b0, 14'h0010, 32'hFFFF_FFFF, 32'h0000_0000);

        wq = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        preload(14'h0100, wq, 2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cpu(1'b1, AW'(14'h0100 + i), '0, '1);
            check("preload_rd", dm_data_out, wq[i]);
        end
        cpu(1'b1, 14'h0010, '0, '1);
        check("idle_wr_blocked", dm_data_out, first_blk[16]);

        cpu(1'b0, 14'h0100, 32'hAABB_CCDD, 32'hFFFF_00FF);
        check("mask_wr_out", dm_data_out, 32'h1111_CC11);
        cpu(1'b1, 14'h0100, '0, '1);
        check("mask_rd", dm_data_out, 32'h1111_CC11);

        cpu(1'b0, 14'h0200, 32'd1, 32'd0);
        cpu(1'b0, 14'h0201, 32'd2, 32'd0);
        cpu(1'b0, 14'h0200, 32'd3, 32'd0);
        cpu(1'b1, 14'h0200, '0, '1);
        check("b2b_rd_200", dm_data_out, 32'd3);
        cpu(1'b1, 14'h0201, '0, '1);
        check("b2b_rd_201", dm_data_out, 32'd2);

        cpu(1'b0, 14'h0101, 32'h5555_5555, 32'hFFFF_FFFF);
        check("noop_store", dm_data_out, 32'h2222_2222);

        // Address wrap during preload.
        do_reset(1);
        wq = {32'hDEAD_BEEF, 32'hCAFE_F00D};
        preload(14'h3FFF, wq, -1, 1'b0);
        cpu(1'b1, 14'h3FFF, '0, '1);
        check("wrap_3fff", dm_data_out, 32'hDEAD_BEEF);
        cpu(1'b1, 14'h0000, '0, '1);
        check("wrap_0000", dm_data_out, 32'hCAFE_F00D);

        // Reset in the middle of a preload.
        do_reset(1);
        ld_start = 1'b1; ld_base = 14'h0300; tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 32'hA0A0_0001; tick();
        ld_data  = 32'hA0A0_0002; tick();
        ld_data  = 32'hA0A0_0003; rst = 1'b1; tick();
        rst = 1'b0;
        check("midrst_ready", {31'b0, ld_ready}, 32'd0);
        check("midrst_done",  {31'b0, ld_done},  32'd0);
        check("midrst_cpu",   {31'b0, cpu_rst},  32'd1);
        ld_last = 1'b1; tick();
        check("idle_ignores_valid", {31'b0, ld_ready}, 32'd0);
        ld_valid = 1'b0; ld_last = 1'b0;
        wq = {32'hA0A0_00FF};
        preload(14'h0302, wq, -1, 1'b0);
        cpu(1'b1, 14'h0300, '0, '1);
        check("midrst_keep0", dm_data_out, 32'hA0A0_0001);
        cpu(1'b1, 14'h0301, '0, '1);
        check("midrst_keep1", dm_data_out, 32'hA0A0_0002);

        // Randomized phases: RUN traffic with junk preload inputs, then reloads.
        for (int r = 0; r < 6; r++) begin
            keys = {};
            foreach (mdl_mem[a]) keys.push_back(a);
            for (int c = 0; c < 80; c++) begin
                k = keys[$urandom_range(keys.size() - 1)];
                ld_start = 1'($urandom_range(1));
                ld_valid = 1'($urandom_range(1));
                ld_last  = 1'($urandom_range(1));
                ld_data  = $urandom;
                ld_base  = AW'($urandom);
                case ($urandom_range(3))
                    0:       dm_bweb = '1;
                    1:       dm_bweb = '0;
                    default: dm_bweb = $urandom;
                endcase
                cpu(1'($urandom_range(1)), AW'(k), $urandom, dm_bweb);
            end
            ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
            if ($urandom_range(1) == 1) do_reset(1);
            else do_reset(2);
            wq = {};
            for (int i = 0; i < int'($urandom_range(8, 1)); i++) wq.push_back($urandom);
            preload(AW'($urandom_range(DEPTH - 1)), wq, -1, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_responder.md
# dm_responder

Memory-side responder for the CPU data-memory port. It holds a 16384 x 32-bit word store and answers the CPU's address, write-enable and bit-mask requests with a one-cycle synchronous read. Before the CPU runs, a handshaked preload port writes program data into the store. The block sits next to the CPU core and drives the core's reset until the preload has finished.

## Interface
Parameters:
- ADDR_W, 14, word-address width.
- DATA_W, 32, data width.
- DEPTH, 16384, number of words (2^ADDR_W).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- dm_addr  in  ADDR_W  word address from the CPU.
- dm_data_in  in  DATA_W  write data from the CPU.
- dm_web  in  1  active-low write enable (0 = write, 1 = read).
- dm_bweb  in  DATA_W  active-low bit write mask (bit = 0 writes that bit).
- dm_data_out  out  DATA_W  registered read data to the CPU.
- ld_start  in  1  pulse that starts a preload.
- ld_base  in  ADDR_W  start word address of the preload, sampled with ld_start.
- ld_valid  in  1  preload word valid.
- ld_data  in  DATA_W  preload word.
- ld_last  in  1  marks the final preload word.
- ld_ready  out  1  responder accepts a preload word this cycle.
- ld_done  out  1  preload complete; stays high while in RUN.
- cpu_rst  out  1  reset to the CPU core; high unless the state is RUN.

## Operation
- FSM states are IDLE, LOAD and RUN. rst forces IDLE from any state. Storage contents are never cleared by reset.
- IDLE:
  - ld_ready=0, ld_done=0, cpu_rst=1.
  - ld_start=1 moves to LOAD and sets ptr to ld_base.
  - ld_valid is ignored.
- LOAD:
  - ld_ready=1.
  - A handshake (ld_valid && ld_ready) writes all 32 bits of ld_data to mem[ptr], then ptr <= ptr+1 modulo DEPTH (0x3FFF wraps to 0x0000).
  - A handshake with ld_last=1 moves to RUN.
  - ld_start is ignored in LOAD.
  - A preload longer than DEPTH words wraps and overwrites earlier words.
- RUN:
  - ld_ready=0, ld_done=1, cpu_rst=0.
  - All ld_* inputs are ignored.
  - The CPU port is serviced as described below.
- CPU port, RUN only:
  - Read (dm_web=1): dm_data_out <= mem[dm_addr].
  - Write (dm_web=0): mem[dm_addr] <= (mem[dm_addr] & dm_bweb) | (dm_data_in & ~dm_bweb). The write is write-first: dm_data_out <= the merged new word.
  - A write with dm_bweb=all-ones is a no-op store, and dm_data_out returns the unchanged word.
- CPU port outside RUN:
  - dm_web and dm_addr are ignored; no store writes occur.
  - dm_data_out holds 0.
- Byte/halfword stores rely on the CPU pre-shifting the data and the mask. The responder applies the mask bit-wise and performs no alignment.

## Timing
- Reset values: dm_data_out=0, ld_ready=0, ld_done=0, cpu_rst=1, state=IDLE, ptr=0.
- cpu_rst is registered-state decoded: it is high in the cycle rst is asserted and in every cycle after that until the state is RUN.
- Read latency is 1 cycle. An address presented in cycle N gives data on dm_data_out in cycle N+1, which matches the CPU's MEM-to-WB capture.
- Back-to-back access:
  - Write to A in cycle N, then read A in cycle N+1: the read returns the merged word in cycle N+2, with no hazard.
  - Reads can issue every cycle.
- Preload: one word per cycle at full rate.
- The ld_last handshake in cycle N gives the following in cycle N+1: state=RUN, ld_ready=0, ld_done=1, cpu_rst=0.
- ld_start in cycle N gives ld_ready=1 in cycle N+1. The first word can be accepted in cycle N+1.
- rst in the middle of LOAD: the next cycle is IDLE with ld_ready=0. Words already written stay in the store. A new ld_start is required.
- rst in RUN: the next cycle is IDLE with cpu_rst=1 and dm_data_out=0.

## Test plan
- Reset: hold rst for 2 cycles. Required: dm_data_out=0, cpu_rst=1, ld_ready=0, ld_done=0. A CPU write to 0x0010 while in IDLE does not change mem[0x0010].
- Preload: ld_start with ld_base=0x0100, then the 4 words 0x11111111, 0x22222222, 0x33333333, 0x44444444 (last on the 4th), with ld_valid dropping for 1 cycle between words 2 and 3. Required:
  - ld_done=1 and cpu_rst=0 exactly one cycle after the 4th handshake.
  - Reads of 0x0100 to 0x0103 return the four words, each 1 cycle after its address.
- Masked write: in RUN, with mem[0x0100]=0x11111111, write dm_data_in=0xAABBCCDD with dm_bweb=0xFFFF00FF. Required:
  - dm_data_out=0x1111CC11 the next cycle.
  - A read of 0x0100 on the following cycle returns 0x1111CC11.
- Wrap: ld_base=0x3FFF with 2 words 0xDEADBEEF then 0xCAFEF00D (last). Required: mem[0x3FFF]=0xDEADBEEF and mem[0x0000]=0xCAFEF00D.
- rst in the middle of LOAD: assert rst after 2 of 4 words. Required:
  - State is IDLE and ld_ready=0; the 2 written words persist.
  - A new ld_start with 1 last word leads to RUN.
- Back-to-back: in RUN, writes to 0x0200, 0x0201 and 0x0200 (full mask, data 1, 2, 3), then reads of 0x0200 and 0x0201. Required: the reads return 3 and 2 on consecutive cycles.
